// File: rtl/bn_res_pipe.sv
// ---------------------------------------------------------------------------
// bn_res_pipe
//
// Batch-norm + residual stage sitting between partial-sum accumulation and
// RPReLU. For every channel of a beat it computes
//
//     data_out = sat( ((bn_a * data_in + round) >>> shift) + bn_b + res )
//
// as a three-stage pipeline with valid/ready handshakes on both sides.
//
//   S1  exact product p = bn_a * data_in, plus bn_b, gated residual and the
//       clamped shift amount captured alongside it
//   S2  round-half-up arithmetic shift, then add bias and residual in a
//       sum wide enough that no intermediate can overflow
//   S3  clamp to the signed DATA_WIDTH range and raise a per-beat flag
//       when any channel clamped
//
// The whole pipe advances on one enable (adv). A stage that holds no beat
// carries a bubble, and bubbles are moved along with everything else rather
// than squeezed out, so the pipe behaves as a fixed-latency shift register
// that freezes when the output is stalled.
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   data_in_valid   input beat valid
//   data_in_ready   input beat accepted this cycle (= adv)
//   data_in         CHANNEL_NUM x IN_WIDTH signed partial sums
//   bn_a, bn_b      CHANNEL_NUM x PARA_WIDTH signed scale / bias
//   res             FM_DEPTH x DATA_WIDTH signed residual
//   res_en          add the residual on this beat
//   shift_amt       right shift applied to the product (>= P acts as P-1)
//   data_out        CHANNEL_NUM x DATA_WIDTH signed result
//   data_out_valid  output beat valid
//   data_out_ready  downstream accepts
//   sat_count       saturating count of output beats with a clamped channel
//
// Channel ch occupies bits [ch*WIDTH +: WIDTH] of every flattened bus.
// ---------------------------------------------------------------------------
module bn_res_pipe #(
    parameter int DATA_WIDTH  = 16,
    parameter int PARA_WIDTH  = 16,
    parameter int IN_WIDTH    = 6,
    parameter int CHANNEL_NUM = 128,
    parameter int FM_DEPTH    = 64,
    parameter int SHIFT_W     = $clog2(PARA_WIDTH + IN_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              data_in_valid,
    output logic                              data_in_ready,
    input  logic [IN_WIDTH*CHANNEL_NUM-1:0]   data_in,
    input  logic [PARA_WIDTH*CHANNEL_NUM-1:0] bn_a,
    input  logic [PARA_WIDTH*CHANNEL_NUM-1:0] bn_b,
    input  logic [DATA_WIDTH*FM_DEPTH-1:0]    res,
    input  logic                              res_en,
    input  logic [SHIFT_W-1:0]                shift_amt,
    output logic [DATA_WIDTH*CHANNEL_NUM-1:0] data_out,
    output logic                              data_out_valid,
    input  logic                              data_out_ready,
    output logic [15:0]                       sat_count
);

    // Product width and internal sum width.
    localparam int P     = PARA_WIDTH + IN_WIDTH;
    localparam int W_PD  = (P > DATA_WIDTH) ? P : DATA_WIDTH;
    localparam int W_MAX = (W_PD > PARA_WIDTH) ? W_PD : PARA_WIDTH;
    localparam int W     = W_MAX + 2;

    localparam logic [SHIFT_W-1:0]    SHIFT_LIMIT = SHIFT_W'(P - 1);
    localparam logic [DATA_WIDTH-1:0] OUT_MAX     = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OUT_MIN     = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // Pipeline enable and per-stage load strobes
    // ------------------------------------------------------------------
    logic adv;
    logic ld1;
    logic ld2;
    logic ld3;

    // Stage 1 state
    logic                                   s1_v_q,  s1_v_d;
    logic [CHANNEL_NUM-1:0][P-1:0]          s1_p_q,  s1_p_d;
    logic [CHANNEL_NUM-1:0][PARA_WIDTH-1:0] s1_b_q,  s1_b_d;
    logic [FM_DEPTH-1:0][DATA_WIDTH-1:0]    s1_r_q,  s1_r_d;
    logic [SHIFT_W-1:0]                     s1_sh_q, s1_sh_d;

    // Stage 2 state
    logic                                   s2_v_q,  s2_v_d;
    logic [CHANNEL_NUM-1:0][W-1:0]          s2_s_q,  s2_s_d;

    // Stage 3 state (drives the outputs)
    logic                                   s3_v_q,  s3_v_d;
    logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] s3_y_q,  s3_y_d;
    logic                                   s3_sat_q, s3_sat_d;

    logic [15:0]                            sat_count_q, sat_count_d;

    // The only combinational input-to-output path: downstream ready
    // reaches data_in_ready through adv.
    assign adv           = ~s3_v_q | data_out_ready;
    assign data_in_ready = adv;

    // Data registers load only when a real beat moves in; bubbles advance
    // through the valid bits alone, which keeps the datapath quiet.
    assign ld1 = adv & data_in_valid;
    assign ld2 = adv & s1_v_q;
    assign ld3 = adv & s2_v_q;

    // ------------------------------------------------------------------
    // Stage 1: exact product and side-band capture
    // ------------------------------------------------------------------
    logic [P-1:0] a_ext;
    logic [P-1:0] x_ext;

    always_comb begin
        a_ext   = '0;
        x_ext   = '0;
        s1_v_d  = adv ? data_in_valid : s1_v_q;
        s1_sh_d = s1_sh_q;
        s1_p_d  = s1_p_q;
        s1_b_d  = s1_b_q;
        s1_r_d  = s1_r_q;

        if (ld1) begin
            // Out-of-range shifts behave as the largest meaningful shift.
            if (int'(shift_amt) > P - 1) begin
                s1_sh_d = SHIFT_LIMIT;
            end else begin
                s1_sh_d = shift_amt;
            end

            for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
                // Both operands are sign-extended to P bits; the low P bits of
                // the unsigned product equal the signed product, which always
                // fits in P bits.
                a_ext = {{IN_WIDTH{bn_a[ch*PARA_WIDTH + PARA_WIDTH - 1]}},
                         bn_a[ch*PARA_WIDTH +: PARA_WIDTH]};
                x_ext = {{PARA_WIDTH{data_in[ch*IN_WIDTH + IN_WIDTH - 1]}},
                         data_in[ch*IN_WIDTH +: IN_WIDTH]};
                s1_p_d[ch] = a_ext * x_ext;
                s1_b_d[ch] = bn_b[ch*PARA_WIDTH +: PARA_WIDTH];
            end

            // Gating the residual here means S2 never needs res_en.
            for (int ch = 0; ch < FM_DEPTH; ch++) begin
                s1_r_d[ch] = res_en ? res[ch*DATA_WIDTH +: DATA_WIDTH] : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round, shift, add bias and residual
    // ------------------------------------------------------------------
    logic [W-1:0] rnd;

    // Half an LSB of the shifted result; adding it before an arithmetic
    // (flooring) shift gives round-half-up toward +inf.
    always_comb begin
        rnd = '0;
        if (s1_sh_q != '0) begin
            rnd = W'(1) << (s1_sh_q - SHIFT_W'(1));
        end
    end

    assign s2_v_d = adv ? s1_v_q : s2_v_q;

    for (genvar ch = 0; ch < CHANNEL_NUM; ch++) begin : g_ch
        logic signed [W-1:0] p_w;
        logic signed [W-1:0] rnd_sum;
        logic signed [W-1:0] shifted;
        logic signed [W-1:0] b_w;
        logic signed [W-1:0] r_w;

        always_comb begin
            p_w     = {{(W-P){s1_p_q[ch][P-1]}}, s1_p_q[ch]};
            rnd_sum = p_w + $signed(rnd);
            shifted = rnd_sum >>> s1_sh_q;
            b_w     = {{(W-PARA_WIDTH){s1_b_q[ch][PARA_WIDTH-1]}}, s1_b_q[ch]};
        end

        // Only the first FM_DEPTH channels carry a residual input at all.
        if (ch < FM_DEPTH) begin : g_res
            assign r_w = {{(W-DATA_WIDTH){s1_r_q[ch][DATA_WIDTH-1]}}, s1_r_q[ch]};
        end else begin : g_no_res
            assign r_w = '0;
        end

        assign s2_s_d[ch] = ld2 ? (shifted + b_w + r_w) : s2_s_q[ch];
    end

    // ------------------------------------------------------------------
    // Stage 3: clamp and per-beat saturation flag
    // ------------------------------------------------------------------
    logic [W-DATA_WIDTH:0] s_hi;
    logic                  any_sat;

    always_comb begin
        s_hi     = '0;
        any_sat  = 1'b0;
        s3_v_d   = adv ? s2_v_q : s3_v_q;
        s3_y_d   = s3_y_q;
        s3_sat_d = s3_sat_q;

        if (ld3) begin
            for (int ch = 0; ch < CHANNEL_NUM; ch++) begin
                // The value fits when every bit from the output sign bit up
                // is a copy of the sign.
                s_hi = s2_s_q[ch][W-1:DATA_WIDTH-1];
                if ((s_hi == '0) || (s_hi == '1)) begin
                    s3_y_d[ch] = s2_s_q[ch][DATA_WIDTH-1:0];
                end else begin
                    any_sat    = 1'b1;
                    s3_y_d[ch] = s2_s_q[ch][W-1] ? OUT_MIN : OUT_MAX;
                end
            end
            s3_sat_d = any_sat;
        end
    end

    // ------------------------------------------------------------------
    // Saturated-beat counter, counted on output transfer, sticks at max
    // ------------------------------------------------------------------
    always_comb begin
        sat_count_d = sat_count_q;
        if (s3_v_q && data_out_ready && s3_sat_q && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            s3_v_q      <= 1'b0;
            s3_y_q      <= '0;
            s3_sat_q    <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s2_v_q      <= s2_v_d;
            s3_v_q      <= s3_v_d;
            s3_y_q      <= s3_y_d;
            s3_sat_q    <= s3_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    // Interior datapath needs no reset: its contents are ignored until the
    // matching valid bit is set.
    always_ff @(posedge clk) begin
        s1_p_q  <= s1_p_d;
        s1_b_q  <= s1_b_d;
        s1_r_q  <= s1_r_d;
        s1_sh_q <= s1_sh_d;
        s2_s_q  <= s2_s_d;
    end

    assign data_out       = s3_y_q;
    assign data_out_valid = s3_v_q;
    assign sat_count      = sat_count_q;

endmodule

// File: tb/tb_bn_res_pipe.sv
module tb_bn_res_pipe;

    localparam int DW  = 16;
    localparam int PW  = 16;
    localparam int IW  = 6;
    localparam int NCH = 8;
    localparam int FM  = 4;
    localparam int P   = PW + IW;
    localparam int SW  = $clog2(P);

    typedef struct packed {
        logic [IW*NCH-1:0] x;
        logic [PW*NCH-1:0] a;
        logic [PW*NCH-1:0] b;
        logic [DW*FM-1:0]  r;
        logic              en;
        logic [SW-1:0]     sh;
    } beat_t;

    typedef struct packed {
        logic [DW*NCH-1:0] y;
        logic              sat;
    } exp_t;

    typedef struct {
        int a;
        int x;
        int b;
        int res;
        int en;
        int sh;
        int exp0;
        int expf;
        int sat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    beat_t cur;

    logic              data_in_ready;
    logic [DW*NCH-1:0] data_out;
    logic              data_out_valid;
    logic [15:0]       sat_count;

    always #5 clk = ~clk;

    bn_res_pipe #(
        .DATA_WIDTH (DW),
        .PARA_WIDTH (PW),
        .IN_WIDTH   (IW),
        .CHANNEL_NUM(NCH),
        .FM_DEPTH   (FM),
        .SHIFT_W    (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in_valid (in_valid),
        .data_in_ready (data_in_ready),
        .data_in       (cur.x),
        .bn_a          (cur.a),
        .bn_b          (cur.b),
        .res           (cur.r),
        .res_en        (cur.en),
        .shift_amt     (cur.sh),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(out_ready),
        .sat_count     (sat_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_sat = 0;
    vec_t vecs[14];

    task automatic chk_i(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic chk_v(input string name, input logic [DW*NCH-1:0] act, input logic [DW*NCH-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // floor(n / d) for d > 0
    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: real-number definition, round-half-up, clamp to DW bits.
    function automatic exp_t model(input beat_t bt);
        exp_t   e;
        longint p, r, s, lim_hi, lim_lo;
        int     sh;
        logic [63:0] s_bits;
        e      = '0;
        lim_hi = (longint'(1) << (DW - 1)) - 1;
        lim_lo = -(longint'(1) << (DW - 1));
        sh     = int'(bt.sh);
        if (sh > P - 1) sh = P - 1;
        for (int ch = 0; ch < NCH; ch++) begin
            p = longint'($signed(bt.a[ch*PW +: PW])) * longint'($signed(bt.x[ch*IW +: IW]));
            if (sh == 0) r = p;
            else r = fdiv(p + (longint'(1) << (sh - 1)), longint'(1) << sh);
            s = r + longint'($signed(bt.b[ch*PW +: PW]));
            if (ch < FM && bt.en) s = s + longint'($signed(bt.r[ch*DW +: DW]));
            if (s > lim_hi) begin s = lim_hi; e.sat = 1'b1; end
            if (s < lim_lo) begin s = lim_lo; e.sat = 1'b1; end
            s_bits = s;
            e.y[ch*DW +: DW] = s_bits[DW-1:0];
        end
        return e;
    endfunction

    function automatic beat_t vec_beat(input vec_t v);
        beat_t bt;
        bt = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            bt.a[ch*PW +: PW] = PW'(v.a);
            bt.x[ch*IW +: IW] = IW'(v.x);
            bt.b[ch*PW +: PW] = PW'(v.b);
        end
        for (int ch = 0; ch < FM; ch++) bt.r[ch*DW +: DW] = DW'(v.res);
        bt.en = (v.en != 0);
        bt.sh = SW'(v.sh);
        return bt;
    endfunction

    // mode 0: random, mode 1: value k+1 on every channel, mode 2: alternating config
    function automatic beat_t gen_beat(input int mode, input int idx);
        beat_t bt;
        bt = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            bt.a[ch*PW +: PW] = PW'($urandom);
            bt.x[ch*IW +: IW] = IW'($urandom);
            bt.b[ch*PW +: PW] = PW'($urandom);
        end
        for (int ch = 0; ch < FM; ch++) bt.r[ch*DW +: DW] = DW'($urandom);
        bt.en = 1'($urandom_range(0, 1));
        bt.sh = SW'($urandom_range(0, (1 << SW) - 1));
        if (mode == 1) begin
            for (int ch = 0; ch < NCH; ch++) begin
                bt.a[ch*PW +: PW] = PW'(1);
                bt.x[ch*IW +: IW] = IW'(idx + 1);
                bt.b[ch*PW +: PW] = '0;
            end
            bt.en = 1'b0;
            bt.sh = '0;
        end else if (mode == 2) begin
            bt.en = (idx % 2 == 0);
            bt.sh = (idx % 2 == 0) ? SW'(8) : SW'(4);
        end
        return bt;
    endfunction

    // Single beat through an empty pipe; called at posedge+1, returns at posedge+1.
    task automatic apply_vec(input int i);
        int lat;
        cur       = vec_beat(vecs[i]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk_i($sformatf("v%0d_in_ready", i), longint'(data_in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (data_out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        chk_i($sformatf("v%0d_latency", i), lat, 3);
        chk_i($sformatf("v%0d_ch0", i), longint'($signed(data_out[0 +: DW])), vecs[i].exp0);
        chk_i($sformatf("v%0d_chfm", i), longint'($signed(data_out[FM*DW +: DW])), vecs[i].expf);
        @(posedge clk); #1;
        exp_sat = exp_sat + vecs[i].sat;
        chk_i($sformatf("v%0d_sat_count", i), longint'(sat_count), exp_sat);
    endtask

    // Streaming with scoreboard; called at posedge+1, returns at posedge+1.
    task automatic run_stream(input int nbeats, input int mode, input int max_cyc);
        exp_t              q[$];
        exp_t              e;
        int                sent, got, cyc;
        logic              in_fire, stall_prev;
        logic [DW*NCH-1:0] held;
        sent = 0; got = 0; cyc = 0;
        stall_prev = 1'b0;
        held = '0;
        in_valid = 1'b0;
        while ((got < nbeats) && (cyc < max_cyc)) begin
            if (!in_valid && (sent < nbeats) && (mode != 0 || $urandom_range(0, 3) != 0)) begin
                cur      = gen_beat(mode, sent);
                in_valid = 1'b1;
            end
            if (mode == 1) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            else if (mode == 0) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = 1'b1;
            @(negedge clk);
            chk_i($sformatf("m%0d_sat_count", mode), longint'(sat_count), exp_sat);
            chk_i($sformatf("m%0d_in_ready", mode), longint'(data_in_ready),
                  longint'(!data_out_valid || out_ready));
            if (stall_prev) begin
                chk_i($sformatf("m%0d_stall_valid", mode), longint'(data_out_valid), 1);
                chk_v($sformatf("m%0d_stall_hold", mode), data_out, held);
            end
            in_fire = in_valid && data_in_ready;
            if (in_fire) begin
                q.push_back(model(cur));
                sent++;
            end
            if (data_out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk_i($sformatf("m%0d_spurious_out", mode), 1, 0);
                end else begin
                    e = q.pop_front();
                    chk_v($sformatf("m%0d_beat%0d", mode, got), data_out, e.y);
                    if (e.sat && exp_sat != 16'hFFFF) exp_sat++;
                end
                got++;
            end
            stall_prev = data_out_valid && !out_ready;
            held       = data_out;
            @(posedge clk); #1;
            if (in_fire) in_valid = 1'b0;
            cyc++;
        end
        chk_i($sformatf("m%0d_beats_out", mode), got, nbeats);
        chk_i($sformatf("m%0d_queue_empty", mode), q.size(), 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{256,    5,   3,      10,  1, 8,  18,     8,      0};
        vecs[1]  = '{-384,   1,   0,      10,  0, 8,  -1,     -1,     0};
        vecs[2]  = '{384,    1,   0,      10,  0, 8,  2,      2,      0};
        vecs[3]  = '{7,      -3,  0,      0,   0, 0,  -21,    -21,    0};
        vecs[4]  = '{32767,  31,  0,      0,   0, 0,  32767,  32767,  1};
        vecs[5]  = '{-32768, 31,  0,      0,   0, 0,  -32768, -32768, 1};
        vecs[6]  = '{3,      1,   0,      0,   0, 1,  2,      2,      0};
        vecs[7]  = '{-3,     1,   0,      0,   0, 1,  -1,     -1,     0};
        vecs[8]  = '{-32768, -32, 5,      100, 1, 31, 106,    6,      0};
        vecs[9]  = '{-32768, -32, 0,      0,   0, 22, 1,      1,      0};
        vecs[10] = '{-1,     -1,  -5,     -20, 1, 0,  -24,    -4,     0};
        vecs[11] = '{0,      0,   32767,  1,   1, 0,  32767,  32767,  1};
        vecs[12] = '{0,      0,   -32768, -1,  1, 0,  -32768, -32768, 1};
        vecs[13] = '{0,      0,   32767,  0,   1, 0,  32767,  32767,  0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cur       = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_i("rst_out_valid", longint'(data_out_valid), 0);
        chk_i("rst_sat_count", longint'(sat_count), 0);
        chk_v("rst_data_out", data_out, '0);
        chk_i("rst_in_ready", longint'(data_in_ready), 1);
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) apply_vec(i);

        run_stream(10, 1, 200);
        run_stream(12, 2, 200);
        run_stream(250, 0, 3000);

        // Reset with three beats in flight.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cur      = vec_beat(vecs[4]);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk_i("pre_rst_valid", longint'(data_out_valid), 1);
        chk_i("pre_rst_sat_nonzero", longint'(sat_count != 16'd0), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_i("midrst_out_valid", longint'(data_out_valid), 0);
        chk_i("midrst_sat_count", longint'(sat_count), 0);
        chk_v("midrst_data_out", data_out, '0);
        chk_i("midrst_in_ready", longint'(data_in_ready), 1);
        exp_sat = 0;
        @(posedge clk); #1;
        apply_vec(0);
        run_stream(20, 0, 400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
